mmio_pwm_led: RTL and testbench
===============================

# mmio_pwm_led

Memory-mapped peripheral responder on the single-cycle RISC-V core's data bus. It decodes core stores (`MemWrite`/`DataAdr`/`WriteData`) into a window of control registers, returns register contents on loads, and drives the board LEDs and a bank of prescaled, glitch-free PWM channels. It sits beside data memory in `top`, and `top` muxes its `ReadData` when an address hits its window.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: base of the 256-byte register window (aligned to 256).
- `NUM_CH`, default 4: PWM channel count, 1..8.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `MemWrite` in 1: core store strobe, sampled on the rising edge of `clk`.
- `DataAdr` in 32: core byte address. Bits [1:0] are ignored; only word access is supported.
- `WriteData` in 32: store data.
- `hit` out 1: combinational. High when `DataAdr[31:8] == BASE_ADDR[31:8]`.
- `ReadData` out 32: combinational load data. Zero when `hit` is low or the offset is unmapped.
- `leds` out 4: LED register, registered.
- `pwm_out` out NUM_CH: PWM outputs, registered.

## Operation
Register map, by offset (`DataAdr[7:0]`):
- 0x00 LED: RW. Bits [3:0] drive `leds`. Reset 0.
- 0x04 CTRL: RW. Bit 0 is `en`. Reset 0.
- 0x08 PERIOD: RW, 16 bits. Reset 16'h00FF.
- 0x0C PRESCALE: RW, 16 bits. Reset 0.
- 0x10 COUNT: RO, 16 bits. Returns the current PWM counter value.
- 0x20 + 4·i, for i < NUM_CH, DUTY[i]: RW, 16 bits. Reads return the staged value. Reset 0.

Register access rules:
- Reads and writes to unmapped offsets: reads return 0, writes are ignored. Writes to COUNT are ignored.
- Unused upper register bits read 0 and are ignored on write.

Write rules:
- A write commits on a rising edge where `MemWrite && hit`.
- The new value is visible on `ReadData` in the following cycle.
- Writing PERIOD or CTRL also clears the prescaler and COUNT to 0 on the same edge.

PWM engine (all state held at reset values while `en` = 0):
- Prescaler `ps` counts 0..PRESCALE. A `tick` occurs in any cycle where `ps == PRESCALE`, and `ps` then returns to 0.
- On `tick`, COUNT increments. When COUNT == PERIOD it wraps to 0. The PWM period is therefore (PERIOD+1)·(PRESCALE+1) clocks.
- DUTY writes go to a staging register. The active duty `act[i]` loads from staging only at a wrap (tick with COUNT == PERIOD), at reset, or at any CTRL/PERIOD write. This gives glitch-free duty updates.
- `pwm_out[i]` is registered as `en && (COUNT < act[i])`:
  - `act` = 0 gives a constant low output.
  - `act` > PERIOD gives a constant high output.

Boundary cases:
- PERIOD = 0: COUNT stays 0. Output is high iff `act` ≥ 1.
- PRESCALE = 0: a tick occurs every cycle.
- A write to DUTY in the same cycle as a wrap: the wrap latches the old staged value, and the new value applies at the next wrap.
- `reset` asserted mid-period: all registers, `ps`, COUNT, `act`, `leds`, and `pwm_out` return to reset values on that edge. Reset has priority over a simultaneous write.

## Timing
- Reset values: `leds` = 0, `pwm_out` = 0, `ReadData` = 0 (since `hit` is low at address 0), COUNT = 0.
- Load latency is 0 cycles, because `ReadData` is combinational from the registers. This is required by the single-cycle core.
- Store latency: the register updates at the storing edge. `leds` changes on that same edge.
- `pwm_out` lags the COUNT/`act` comparison by 1 clock.
- CTRL `en` 0→1 at edge T: COUNT = 0 from T. The first `pwm_out` high (if `act` > 0) appears after edge T+1.

## Test plan
- **Reset and readback:** hold `reset` for 2 cycles, then read every offset. Expect PERIOD = 0x00FF, every other register 0, `leds` = 0, `pwm_out` = 0.
- **LED write:** store 0xA to BASE+0x00. Expect `leds` = 4'hA the next cycle and readback 0x0000000A. A store of 0x5 to 0x000000FC (outside the window) must leave `leds` = 0xA.
- **Basic PWM:** PERIOD = 9, PRESCALE = 0, DUTY[0] = 3, then CTRL = 1. Expect `pwm_out[0]` high 3 of every 10 clocks with period exactly 10. Expect COUNT readback to cycle 0..9.
- **Prescale and extremes:** PRESCALE = 3, PERIOD = 4. DUTY[1] = 0 must give a constant low output. DUTY[2] = 5 must give a constant high output. DUTY[3] = 2 must give 8 clocks high of every 20.
- **Shadowed duty:** while running, write DUTY[0] = 7 mid-period. The current period must keep the old high width, and the new width of 7 must apply from the first cycle after the wrap.
- **Mid-run reset:** assert `reset` while COUNT = 5. Expect all outputs 0, PERIOD = 0xFF, `en` = 0 at the next edge, and no further `pwm_out` toggling.

Source files
------------

// File: rtl/mmio_pwm_led_if.sv
// Core data-bus view of the PWM/LED peripheral: store strobe, address, data,
// plus the window-hit flag and combinational load data returned to the core.
interface mmio_pwm_led_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        hit;
    logic [31:0] ReadData;

    modport master (output MemWrite, DataAdr, WriteData, input hit, ReadData);
    modport slave  (input MemWrite, DataAdr, WriteData, output hit, ReadData);
endinterface

// File: rtl/mmio_pwm_led.sv
// Memory-mapped LED register plus a bank of prescaled PWM channels whose duty
// values are staged and only take effect at a period wrap or a restart.
module mmio_pwm_led #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned NUM_CH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    mmio_pwm_led_if.slave     bus,
    output logic [3:0]        leds,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [5:0] W_LED      = 6'd0;
    localparam logic [5:0] W_CTRL     = 6'd1;
    localparam logic [5:0] W_PERIOD   = 6'd2;
    localparam logic [5:0] W_PRESCALE = 6'd3;
    localparam logic [5:0] W_COUNT    = 6'd4;

    logic [3:0]        r_led;
    logic              r_en;
    logic [15:0]       r_period;
    logic [15:0]       r_prescale;
    logic [15:0]       r_ps;
    logic [15:0]       r_count;
    logic [15:0]       r_duty [NUM_CH];
    logic [15:0]       r_act  [NUM_CH];
    logic [NUM_CH-1:0] r_pwm;

    logic [5:0]        w_word;
    logic              w_hit;
    logic              w_we;
    logic              w_restart;
    logic              w_tick;
    logic [NUM_CH-1:0] w_duty_we;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_word    = bus.DataAdr[7:2];
    assign w_hit     = (bus.DataAdr[31:8] == BASE_ADDR[31:8]);
    assign w_we      = bus.MemWrite && w_hit;
    assign w_restart = w_we && ((w_word == W_CTRL) || (w_word == W_PERIOD));
    // >= keeps ps within 0..PRESCALE even if PRESCALE shrinks mid-count
    assign w_tick    = (r_ps >= r_prescale);
    assign w_unused  = ^{bus.DataAdr[1:0], bus.WriteData[31:16]};

    always_comb begin
        w_duty_we = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_we && (w_word == 6'(8 + i))) w_duty_we[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led      <= '0;
            r_en       <= 1'b0;
            r_period   <= 16'h00FF;
            r_prescale <= '0;
            r_ps       <= '0;
            r_count    <= '0;
            r_pwm      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
                r_act[i]  <= '0;
            end
        end else begin
            if (w_we) begin
                case (w_word)
                    W_LED:      r_led      <= bus.WriteData[3:0];
                    W_CTRL:     r_en       <= bus.WriteData[0];
                    W_PERIOD:   r_period   <= bus.WriteData[15:0];
                    W_PRESCALE: r_prescale <= bus.WriteData[15:0];
                    default:    ;
                endcase
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_duty_we[i]) r_duty[i] <= bus.WriteData[15:0];
                r_pwm[i] <= r_en && (r_count < r_act[i]);
            end

            // act always samples the pre-edge staging value, so a DUTY write
            // coinciding with a wrap lands at the following wrap
            if (w_restart) begin
                r_ps    <= '0;
                r_count <= '0;
                r_act   <= r_duty;
            end else if (!r_en) begin
                r_ps    <= '0;
                r_count <= '0;
            end else if (w_tick) begin
                r_ps <= '0;
                if (r_count >= r_period) begin
                    r_count <= '0;
                    r_act   <= r_duty;
                end else begin
                    r_count <= r_count + 16'd1;
                end
            end else begin
                r_ps <= r_ps + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_word)
                W_LED:      w_rdata = {28'd0, r_led};
                W_CTRL:     w_rdata = {31'd0, r_en};
                W_PERIOD:   w_rdata = {16'd0, r_period};
                W_PRESCALE: w_rdata = {16'd0, r_prescale};
                W_COUNT:    w_rdata = {16'd0, r_count};
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (w_word == 6'(8 + i)) w_rdata = {16'd0, r_duty[i]};
                    end
                end
            endcase
        end
    end

    assign bus.hit      = w_hit;
    assign bus.ReadData = w_rdata;
    assign leds         = r_led;
    assign pwm_out      = r_pwm;

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Bench for mmio_pwm_led: directed bring-up sequences plus random bus traffic,
// all compared against a time-based model of the PWM (elapsed clocks since restart).
module tb_mmio_pwm_led;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     leds;
    logic [NCH-1:0] pwm_out;

    mmio_pwm_led_if bus ();

    mmio_pwm_led #(.BASE_ADDR(BASE), .NUM_CH(NCH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .leds    (leds),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: the counter value is derived from clocks elapsed since
    // the last restart rather than from a prescaler/counter pair.
    bit [3:0]    m_led;
    bit          m_en;
    int unsigned m_per, m_pre;
    int unsigned m_duty [NCH];
    int unsigned m_act  [NCH];
    longint      m_t;
    bit [NCH-1:0] m_pwm;

    function automatic int unsigned m_count();
        return int'((m_t / (longint'(m_pre) + 1)) % (longint'(m_per) + 1));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned w;
        if (a[31:8] != BASE[31:8]) return 32'd0;
        w = a[7:2];
        case (w)
            0: return {28'd0, m_led};
            1: return {31'd0, m_en};
            2: return m_per;
            3: return m_pre;
            4: return m_count();
            default: return (w >= 8 && w < 8 + NCH) ? m_duty[w-8] : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = '0; m_en = 0; m_per = 255; m_pre = 0; m_t = 0; m_pwm = '0;
        for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_act[i] = 0; end
    endtask

    task automatic model_edge(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit [NCH-1:0] pwm_n;
        int unsigned od [NCH];
        longint L;
        int unsigned w;
        bit hitw, restart, old_en;
        for (int i = 0; i < NCH; i++) pwm_n[i] = m_en && (m_count() < m_act[i]);
        if (rst) begin
            model_reset();
            return;
        end
        od = m_duty;
        old_en = m_en;
        L = (longint'(m_per) + 1) * (longint'(m_pre) + 1);
        hitw = we && (a[31:8] == BASE[31:8]);
        w = a[7:2];
        restart = hitw && (w == 1 || w == 2);
        if (hitw) begin
            case (w)
                0: m_led = d[3:0];
                1: m_en  = d[0];
                2: m_per = d[15:0];
                3: m_pre = d[15:0];
                default: if (w >= 8 && w < 8 + NCH) m_duty[w-8] = d[15:0];
            endcase
        end
        if (restart) begin
            m_t = 0;
            m_act = od;
        end else if (!old_en) begin
            m_t = 0;
        end else begin
            m_t = (m_t + 1) % L;
            if (m_t == 0) m_act = od;
        end
        m_pwm = pwm_n;
    endtask

    task automatic step(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst;
        bus.MemWrite = we;
        bus.DataAdr = a;
        bus.WriteData = d;
        model_edge(rst, we, a, d);
        @(posedge clk);
        #1;
        check("leds", leds, m_led);
        check("pwm_out", pwm_out, m_pwm);
        check("rdata", bus.ReadData, m_read(a));
        check("hit", bus.hit, a[31:8] == BASE[31:8]);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        step(0, 1, BASE + off, d);
    endtask

    task automatic rd(input logic [7:0] off);
        step(0, 0, BASE + off, 32'd0);
    endtask

    initial begin
        int hi, hi1, hi2, hi3, toggles;
        bit found;
        logic [NCH-1:0] prev;
        reset = 1'b1;
        bus.MemWrite = 1'b0;
        bus.DataAdr = '0;
        bus.WriteData = '0;
        model_reset();

        step(1, 0, 32'd0, 32'd0);
        step(1, 0, 32'd0, 32'd0);
        check("rst_rdata_addr0", bus.ReadData, 32'd0);
        for (int off = 0; off <= 8'h2C; off += 4) rd(8'(off));
        rd(8'h08);
        check("rst_period", bus.ReadData, 32'h0000_00FF);

        wr(8'h00, 32'hA);
        check("led_write", leds, 4'hA);
        rd(8'h00);
        check("led_readback", bus.ReadData, 32'h0000_000A);
        step(0, 1, 32'h0000_00FC, 32'h5);
        check("led_outside", leds, 4'hA);

        wr(8'h08, 9);
        wr(8'h0C, 0);
        wr(8'h20, 3);
        wr(8'h04, 1);
        hi = 0;
        for (int k = 1; k <= 30; k++) begin
            rd(8'h10);
            check("count_seq", bus.ReadData, 32'(k % 10));
            hi += int'(pwm_out[0]);
        end
        check("basic_highs", hi, 9);

        wr(8'h0C, 3);
        wr(8'h08, 4);
        wr(8'h24, 0);
        wr(8'h28, 5);
        wr(8'h2C, 2);
        wr(8'h04, 1);
        hi1 = 0; hi2 = 0; hi3 = 0;
        for (int k = 0; k < 40; k++) begin
            rd(8'h10);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
            hi3 += int'(pwm_out[3]);
        end
        check("duty0_low", hi1, 0);
        check("dutyover_high", hi2, 40);
        check("duty2_highs", hi3, 16);

        wr(8'h0C, 0);
        wr(8'h08, 9);
        wr(8'h20, 3);
        wr(8'h04, 1);
        hi = 0;
        for (int k = 0; k < 4; k++) begin rd(8'h10); hi += int'(pwm_out[0]); end
        check("shadow_old", hi, 3);
        wr(8'h20, 7);
        check("shadow_mid", pwm_out[0], 1'b0);
        hi = 0;
        for (int k = 0; k < 20; k++) begin rd(8'h10); hi += int'(pwm_out[0]); end
        check("shadow_new", hi, 12);

        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            rd(8'h10);
            if (bus.ReadData == 32'd5) found = 1;
        end
        check("count5_reached", found, 1'b1);
        step(1, 0, BASE + 32'h08, 32'd0);
        check("midrst_period", bus.ReadData, 32'h0000_00FF);
        check("midrst_leds", leds, 4'h0);
        check("midrst_pwm", pwm_out, '0);
        rd(8'h04);
        check("midrst_en", bus.ReadData, 32'd0);
        toggles = 0;
        prev = pwm_out;
        for (int k = 0; k < 20; k++) begin
            rd(8'h10);
            if (pwm_out != prev) toggles++;
            prev = pwm_out;
        end
        check("midrst_no_toggle", toggles, 0);

        // PRESCALE is only rewritten while stopped so the elapsed-time model stays exact
        for (int n = 0; n < 600; n++) begin
            int r, sel;
            logic [7:0] off;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1, 0, BASE, 32'd0);
            end else if (r < 40) begin
                sel = $urandom_range(0, 12);
                off = 8'(sel * 4);
                d = $urandom;
                if (off == 8'h08) d &= 32'hFFFF_0007;
                if (off == 8'h0C) begin
                    if (m_en) off = 8'h10;
                    else d &= 32'hFFFF_0003;
                end
                if (off >= 8'h20) d &= 32'hFFFF_000F;
                wr(off, d);
            end else if (r < 45) begin
                step(0, 1, ($urandom_range(0, 1) != 0) ? 32'h0000_00FC : BASE - 32'd4, $urandom);
            end else begin
                rd(8'($urandom_range(0, 12) * 4));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
